// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared architectural definitions for the fetch stage: datapath width, the
//   NOP encoding, the instruction type field, and the prefetch queue entry
//   layout ({instr, pc}, 64 bits).
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  // All-zero word decodes as a NOP; presented whenever nothing valid issues.
  localparam word_t NOP = 32'h0000_0000;

  // Instruction type field position.
  localparam int unsigned ITYPE_HI = 31;
  localparam int unsigned ITYPE_LO = 27;
  localparam int unsigned ITYPE_W  = ITYPE_HI - ITYPE_LO + 1;

  // One prefetch queue entry; instr occupies the upper half.
  typedef struct packed {
    word_t instr;
    word_t pc;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [ITYPE_W-1:0] instr_type(input word_t instr);
    return instr[ITYPE_HI:ITYPE_LO];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous circular FIFO holding prefetched {instr, pc} entries.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset
//     flush           synchronous clear; wins over push and pop
//     push, push_data write an entry at the tail (ignored when full)
//     pop             retire the head entry (ignored when empty)
//     count           occupied entries, 0..DEPTH
//     head_data       oldest entry, combinational; undefined when count == 0
// -----------------------------------------------------------------------------
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [PTR_W:0]   count,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] entries_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_q != FULL_CNT) && !flush;
  assign do_pop  = pop  && (count_q != '0)       && !flush;

  // NOTE: every _d gets its hold value first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer wrap is mod DEPTH.
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W + 1)'(1);
        2'b01:   count_d = count_q - (PTR_W + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count/pointers decide which slots
  // are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) entries_q[tail_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = entries_q[head_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Pipelined fetch stage in front of the issue register. Reads instructions
//   through memory port 0 (one-cycle read latency), buffers them with their PC
//   in a DEPTH-entry prefetch queue, and presents the oldest to decode through
//   a valid/ready handshake. A jump redirect flushes everything and refetches.
//   Ports:
//     clk, rst                     clock, asynchronous active-low reset
//     mem_req, mem_raddr           read request / word address (= fetch_pc)
//     mem_rdata                    read data, valid the cycle after mem_req
//     issue_valid/instr/pc         queue head to decode (NOP / 0 when invalid)
//     issue_ready                  decode accepts the head this cycle
//     redirect_valid/addr          taken jump and its target word address
//     busy_count                   occupied queue entries (debug)
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic [31:0]      mem_raddr,
  input  logic [31:0]      mem_rdata,
  output logic             issue_valid,
  output logic [31:0]      issue_instr,
  output logic [31:0]      issue_pc,
  input  logic             issue_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_addr,
  output logic [PTR_W:0]   busy_count
);

  localparam logic [PTR_W+1:0] CREDIT_LIMIT = (PTR_W + 2)'(DEPTH);

  word_t            fetch_pc_q, fetch_pc_d;
  word_t            req_pc_q,   req_pc_d;
  logic             inflight_q, inflight_d;
  logic             squash_q,   squash_d;

  logic [PTR_W:0]   count;
  logic [PTR_W+1:0] credit;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Occupied slots plus the response still on its way: requesting only while
  // this is below DEPTH guarantees every response has a slot to land in.
  assign credit = {1'b0, count} + {{(PTR_W + 1){1'b0}}, inflight_q};

  // rst gates the request so the port is quiet while reset is held.
  assign mem_req   = rst && !redirect_valid && (credit < CREDIT_LIMIT);
  assign mem_raddr = fetch_pc_q;

  // A response is dropped if it belongs to a squashed request or a redirect
  // is flushing the queue in the cycle it arrives.
  assign push             = inflight_q && !squash_q && !redirect_valid;
  assign push_entry.instr = mem_rdata;
  assign push_entry.pc    = req_pc_q;

  assign issue_valid = (count != '0) && !redirect_valid;
  assign pop         = issue_valid && issue_ready;
  assign issue_instr = issue_valid ? head_entry.instr : NOP;
  assign issue_pc    = issue_valid ? head_entry.pc    : '0;
  assign busy_count  = count;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    squash_d   = squash_q;
    if (redirect_valid) begin
      // Last redirect wins: each one simply overwrites the fetch address.
      fetch_pc_d = redirect_addr;
      squash_d   = inflight_q;
      inflight_d = 1'b0;
    end else if (mem_req) begin
      fetch_pc_d = fetch_pc_q + 32'd1;
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
      squash_d   = 1'b0;
    end else begin
      inflight_d = 1'b0;
    end
  end

  // Clearing inflight on reset discards any response still in the memory pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (ENTRY_W)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head_data (head_entry)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Drives instr_fetch_unit against a one-cycle-latency memory whose contents
//   are a fixed hash of the address. The reference is a queue of expected PCs:
//   a fetch address becomes a queue entry one cycle after it is requested,
//   issues come off the front, a redirect empties it and restarts fetching.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          PTR_W    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_req;
  logic [31:0]      mem_raddr;
  logic [31:0]      mem_rdata = '0;
  logic             issue_valid;
  logic [31:0]      issue_instr;
  logic [31:0]      issue_pc;
  logic             issue_ready;
  logic             redirect_valid;
  logic [31:0]      redirect_addr;
  logic [PTR_W:0]   busy_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] salt;

  // Reference state.
  logic [31:0] q_model [$];
  bit          pend;
  logic [31:0] pend_addr;
  logic [31:0] fetch_addr;

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .PTR_W    (PTR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .issue_valid    (issue_valid),
    .issue_instr    (issue_instr),
    .issue_pc       (issue_pc),
    .issue_ready    (issue_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .busy_count     (busy_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory port 0: data for a request appears the following cycle; garbage
  // otherwise, so any use of an unrequested response shows up.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? mem_word(mem_raddr) : $urandom();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_model.delete();
    pend       = 1'b0;
    pend_addr  = '0;
    fetch_addr = RESET_PC;
  endtask

  // Called shortly after a rising edge; drives inputs, checks at the falling
  // edge, advances the reference, and returns just after the next rising edge.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] raddr);
    bit exp_valid;
    bit exp_req;
    issue_ready    = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    @(negedge clk);
    exp_valid = (q_model.size() != 0) && !redir;
    exp_req   = !redir && ((q_model.size() + int'(pend)) < DEPTH);
    check("busy_count", 32'(busy_count), 32'(q_model.size()));
    check("issue_valid", 32'(issue_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("issue_pc", issue_pc, q_model[0]);
      check("issue_instr", issue_instr, mem_word(q_model[0]));
    end else begin
      check("nop_pc", issue_pc, 32'h0);
      check("nop_instr", issue_instr, 32'h0);
    end
    check("mem_req", 32'(mem_req), 32'(exp_req));
    if (exp_req) check("mem_raddr", mem_raddr, fetch_addr);

    if (redir) begin
      q_model.delete();
      pend       = 1'b0;
      fetch_addr = raddr;
    end else begin
      if (exp_valid && rdy) void'(q_model.pop_front());
      if (pend) q_model.push_back(pend_addr);
      pend = exp_req;
      if (exp_req) begin
        pend_addr  = fetch_addr;
        fetch_addr = fetch_addr + 32'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset away from the clock edge, checks outputs immediately, holds
  // for two edges and releases; returns just after a rising edge.
  task automatic do_reset();
    rst            = 1'b0;
    issue_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_issue_valid", 32'(issue_valid), 32'h0);
    check("rst_issue_instr", issue_instr, 32'h0);
    check("rst_issue_pc", issue_pc, 32'h0);
    check("rst_busy", 32'(busy_count), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    salt = $urandom() | 32'h1;
    rst  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset release and straight-line fetch at full throughput.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

    // Stall from reset: queue fills to DEPTH, request stops, head holds word 0.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check("stall_busy_full", 32'(busy_count), 32'(DEPTH));
    check("stall_no_req", 32'(mem_req), 32'h0);
    check("stall_head_pc", issue_pc, RESET_PC);
    check("stall_head_instr", issue_instr, mem_word(RESET_PC));
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0);

    // Redirect with three entries queued and one response in flight.
    for (int i = 0; i < 20 && !(q_model.size() == 3 && pend); i++) step(1'b0, 1'b0, '0);
    check("pre_redirect_busy", 32'(busy_count), 32'd3);
    step(1'b1, 1'b1, 32'h40);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Back-to-back redirects: only the second target is fetched.
    step(1'b1, 1'b1, 32'h10);
    step(1'b1, 1'b1, 32'h20);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Ready toggling every cycle across many pointer wraps.
    for (int i = 0; i < 40; i++) step(logic'(i % 2), 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    // Redirect near the top of the address space to exercise fetch_pc wrap.
    step(1'b1, 1'b1, 32'hFFFF_FFFE);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

    // Randomised mix of stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3))
                                         : ($urandom() & 32'h0000_FFFF);
      step(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 15) == 0), addr);
    end

    // Reset in the middle of a stream with a response in flight.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
    check("pre_reset_inflight_req", 32'(mem_req), 32'h1);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Pipelined fetch stage that sits directly upstream of the issue register.
- Drives the instruction read port (port 0) of dual_port_main_memory and holds returned words in a small prefetch queue, each tagged with its PC.
- Presents the oldest word to decode through a valid/ready handshake.
- Absorbs decode stalls and flushes on jump redirects, replacing the stage-counter-gated PC control.

Parameters:
- DEPTH, 4, prefetch queue entries (power of two, >= 3).
- PTR_W, 2, log2(DEPTH).
- RESET_PC, 32'h0, first word address fetched after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- mem_req  output  1  read request to memory port 0 this cycle.
- mem_raddr  output  32  word address for the read; equals fetch_pc.
- mem_rdata  input  32  read data, valid exactly 1 cycle after mem_req.
- issue_valid  output  1  queue head holds a valid instruction.
- issue_instr  output  32  head instruction; 32'h0 (NOP) when issue_valid is 0.
- issue_pc  output  32  word address of issue_instr; 0 when issue_valid is 0.
- issue_ready  input  1  decode accepts the head this cycle; driven low during a stall.
- redirect_valid  input  1  jump taken; flush and refetch.
- redirect_addr  input  32  jump target word address.
- busy_count  output  PTR_W+1  number of occupied queue entries (debug).

Behaviour:
- Reset (async, rst=0):
  - fetch_pc = RESET_PC.
  - Queue empty; head/tail pointers = 0; inflight = 0; squash = 0.
  - All outputs 0 / NOP.
  - An in-flight response pending when reset asserts is discarded.
- Request:
  - mem_req = !redirect_valid && (count + inflight) < DEPTH, evaluated on registered count and inflight.
  - On mem_req: fetch_pc <= fetch_pc + 1 (32-bit wrap, 0xFFFFFFFF -> 0); req_pc <= fetch_pc; inflight <= 1; squash <= 0.
  - With no request, inflight <= 0.
- Response:
  - Arrives in the cycle after mem_req.
  - If inflight && !squash && !redirect_valid: write {mem_rdata, req_pc} at tail and advance tail mod DEPTH.
- Issue:
  - issue_valid = (count != 0) && !redirect_valid.
  - Dequeue on issue_valid && issue_ready; head advances mod DEPTH.
  - issue_instr and issue_pc are combinational from the head entry; no bypass of mem_rdata.
- Latency: request in cycle N -> written at the end of N+1 -> issue_valid in N+2.
- Throughput: 1 instruction/cycle when issue_ready is held high.
- Count:
  - Enqueue and dequeue in the same cycle: count unchanged.
  - Overflow is impossible because in-flight credit is included in the request check.
  - Full (count = DEPTH): mem_req = 0.
  - Empty: NOP presented.
- Redirect (highest priority):
  - Queue cleared (count = 0, pointers = 0); no dequeue, no enqueue, no mem_req.
  - fetch_pc <= redirect_addr; squash <= inflight, so a response returning next cycle is dropped.
  - Next cycle: mem_req with mem_raddr = redirect_addr.
  - First redirected instruction is valid 2 cycles after that.
  - Back-to-back redirects: the last one wins.
- Stall: with issue_ready = 0, the head is held stable (same instr and pc) and prefetch continues until full.

Decomposition:
- Shared arch package (alongside the existing arch defines):
  - NOP encoding 32'h0.
  - Instruction type field [31:27].
  - Instruction/address width 32.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH / width 64 ({instr, pc}) synchronous FIFO.
  - Async active-low reset and synchronous flush input.
  - Ports: push, pop, count, head data.
- Request/credit and redirect logic stay in instr_fetch_unit.

Test Plan:
- Reset release, memory[0..3] = A, B, C, D, issue_ready = 1 -> mem_req from cycle 0; issue_valid from cycle 2; issues A/0, B/1, C/2, D/3 on consecutive cycles.
- issue_ready = 0 for 10 cycles -> busy_count saturates at 4; mem_req = 0 while full; head stays A/0; after release, A, B, C, D, E issue in order with no gap or duplicate.
- redirect_valid pulse with addr = 0x40 while 3 entries are queued and 1 in flight -> that cycle issue_valid = 0 and mem_req = 0; next cycle mem_raddr = 0x40; stale in-flight word never issued; first issue is word@0x40 / pc 0x40.
- Back-to-back redirects to 0x10 then 0x20 -> only 0x20 is fetched; no word from 0x10 issued.
- Simultaneous enqueue/dequeue at count = 2 with ready toggling every cycle -> count stays consistent; pointer wrap past DEPTH preserves order for 20 sequential words.
- rst asserted mid-stream with an in-flight request -> outputs 0/NOP immediately; after release, fetch restarts at RESET_PC and the old in-flight word is not enqueued.
